// File: rtl/spike_arbiter_pkg.sv
// Shared types and defaults for the spike arbiter: FSM state encoding and
// the default requester count / counter width.
package spike_arbiter_pkg;

  localparam int unsigned NEURON_IN_DEF = 4;
  localparam int unsigned CNT_W_DEF     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FWD   = 2'd1,
    RLS   = 2'd2,
    UPACK = 2'd3
  } arb_state_e;

  // Index width that stays legal for a single requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spike_arbiter_rr_select.sv
// Combinational round-robin selector: first set request at or after ptr_i,
// wrapping around the vector.
module rr_select
  import spike_arbiter_pkg::*;
#(
  parameter int unsigned N     = NEURON_IN_DEF,
  parameter int unsigned IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  always_comb begin
    int unsigned j;
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (32'(ptr_i) + k) % N;
      if (!valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        idx_o    = j[IDX_W-1:0];
        gnt_o[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spike_arbiter_sync.sv
// Generic vector 2-flop synchronizer with synchronous active-low clear.
module spike_arbiter_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spike_arbiter.sv
// Round-robin arbiter bridging NEURON_IN asynchronous 4-phase spike channels
// onto a one-hot downstream request, with a saturating event counter.
module spike_arbiter
  import spike_arbiter_pkg::*;
#(
  parameter int unsigned NEURON_IN = NEURON_IN_DEF,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NEURON_IN-1:0] req_in,
  output logic [NEURON_IN-1:0] ack_in,
  output logic [NEURON_IN-1:0] req_out,
  input  logic [NEURON_IN-1:0] ack_out,
  output logic                 busy,
  output logic [CNT_W-1:0]     evt_cnt
);

  localparam int unsigned IDX_W = idx_width(NEURON_IN);

  arb_state_e           state_q;
  logic [IDX_W-1:0]     idx_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [NEURON_IN-1:0] req_out_q;
  logic [NEURON_IN-1:0] ack_in_q;
  logic                 busy_q;
  logic [CNT_W-1:0]     evt_cnt_q;

  logic [NEURON_IN-1:0] req_s;
  logic [NEURON_IN-1:0] ack_s;
  logic [NEURON_IN-1:0] sel_gnt;
  logic [IDX_W-1:0]     sel_idx;
  logic                 sel_valid;

  spike_arbiter_sync #(.W(NEURON_IN)) u_sync_req (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (req_in),
    .q_o   (req_s)
  );

  spike_arbiter_sync #(.W(NEURON_IN)) u_sync_ack (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ack_out),
    .q_o   (ack_s)
  );

  rr_select #(.N(NEURON_IN), .IDX_W(IDX_W)) u_rr (
    .req_i   (req_s),
    .ptr_i   (ptr_q),
    .gnt_o   (sel_gnt),
    .idx_o   (sel_idx),
    .valid_o (sel_valid)
  );

  // Outputs are loaded on the same edge as the state change, so each output
  // register always reflects the state it belongs to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      ptr_q     <= '0;
      req_out_q <= '0;
      ack_in_q  <= '0;
      busy_q    <= 1'b0;
      evt_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (sel_valid) begin
            idx_q     <= sel_idx;
            req_out_q <= sel_gnt;
            busy_q    <= 1'b1;
            state_q   <= FWD;
          end
        end
        FWD: begin
          if (ack_s[idx_q]) begin
            req_out_q <= '0;
            state_q   <= RLS;
          end
        end
        RLS: begin
          if (!ack_s[idx_q]) begin
            ack_in_q <= NEURON_IN'(1) << idx_q;
            state_q  <= UPACK;
          end
        end
        UPACK: begin
          if (!req_s[idx_q]) begin
            ack_in_q <= '0;
            busy_q   <= 1'b0;
            ptr_q    <= (32'(idx_q) == NEURON_IN - 1) ? '0 : idx_q + IDX_W'(1);
            if (evt_cnt_q != '1) begin
              evt_cnt_q <= evt_cnt_q + CNT_W'(1);
            end
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_out = req_out_q;
  assign ack_in  = ack_in_q;
  assign busy    = busy_q;
  assign evt_cnt = evt_cnt_q;

endmodule

// File: tb/tb_spike_arbiter.sv
// Self-checking bench for spike_arbiter: behavioural upstream requesters and
// downstream responder, grant-order scoreboard, vector table plus corner cases.
module tb_spike_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_in;
  logic [3:0]  ack_in;
  logic [3:0]  req_out;
  logic [3:0]  ack_out;
  logic        busy;
  logic [15:0] evt_cnt;

  logic [3:0]  ack_in_s;
  logic [3:0]  req_out_s;
  logic        busy_s;
  logic [1:0]  evt_cnt_s;

  int checks = 0;
  int errors = 0;

  logic [1:0]  exp_q[$];
  logic [3:0]  prev_req_out = '0;
  int unsigned ack_delay = 4;
  int unsigned ack_cnt = 0;
  logic [3:0]  spur_mask = '0;

  typedef struct {
    logic [3:0]  req;
    int unsigned delay;
    int unsigned ngrant;
    logic [7:0]  order;   // grant i at order[2*i+1 -: 2]
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[5];

  always #5 clk = ~clk;

  spike_arbiter #(.NEURON_IN(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .ack_in(ack_in),
    .req_out(req_out), .ack_out(ack_out), .busy(busy), .evt_cnt(evt_cnt)
  );

  spike_arbiter #(.NEURON_IN(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req_in(req_in), .ack_in(ack_in_s),
    .req_out(req_out_s), .ack_out(ack_out), .busy(busy_s), .evt_cnt(evt_cnt_s)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One clock: sample on the falling edge, then update the environment models.
  task automatic step();
    logic [1:0] e;
    @(negedge clk);
    if (req_out != 4'b0 && prev_req_out == 4'b0) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_grant", 32'(req_out), 32'h0);
      end else begin
        e = exp_q.pop_front();
        chk("grant_order", 32'(req_out), 32'(4'b0001 << e));
      end
    end
    if ($countones(req_out) > 1 || $countones(ack_in) > 1 ||
        (req_out != 4'b0 && ack_in != 4'b0)) begin
      chk("onehot_excl", {24'h0, req_out, ack_in}, 32'h0);
    end
    prev_req_out = req_out;
    if (req_out != 4'b0) begin
      ack_cnt++;
      if (ack_cnt >= ack_delay) ack_out = ack_out | req_out;
    end else begin
      ack_cnt = 0;
      ack_out = spur_mask;
    end
    req_in = req_in & ~ack_in;
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic wait_grant(input string name);
    int unsigned n = 0;
    while (req_out == 4'b0 && n < 100) begin step(); n++; end
    if (n >= 100) chk({name, "_grant_timeout"}, 32'(n), 32'd0);
  endtask

  task automatic wait_idle(input string name);
    int unsigned n = 0;
    while (!(busy == 1'b0 && req_in == 4'b0 && exp_q.size() == 0) && n < 300) begin
      step(); n++;
    end
    if (n >= 300) chk({name, "_idle_timeout"}, 32'(n), 32'd0);
  endtask

  initial begin
    vecs[0] = '{req: 4'b1000, delay: 2, ngrant: 1, order: 8'b00_00_00_11, cnt: 16'd3};
    vecs[1] = '{req: 4'b1111, delay: 4, ngrant: 4, order: 8'b11_10_01_00, cnt: 16'd7};
    vecs[2] = '{req: 4'b1001, delay: 3, ngrant: 2, order: 8'b00_00_11_00, cnt: 16'd9};
    vecs[3] = '{req: 4'b0110, delay: 1, ngrant: 2, order: 8'b00_00_10_01, cnt: 16'd11};
    vecs[4] = '{req: 4'b1010, delay: 5, ngrant: 2, order: 8'b00_00_01_11, cnt: 16'd13};

    rst_n   = 1'b0;
    req_in  = '0;
    ack_out = '0;
    run(3);
    chk("rst_req_out", 32'(req_out), 32'h0);
    chk("rst_ack_in",  32'(ack_in),  32'h0);
    chk("rst_busy",    32'(busy),    32'h0);
    chk("rst_evt_cnt", 32'(evt_cnt), 32'h0);
    rst_n = 1'b1;
    run(2);

    // Reset while in FWD with idx=2, then re-arbitration of the held request.
    ack_delay = 10;
    exp_q.push_back(2'd2);
    req_in = 4'b0100;
    wait_grant("midrst");
    run(2);
    chk("midrst_in_fwd", 32'(req_out), 32'h4);
    rst_n = 1'b0;
    step();
    chk("midrst_req_out", 32'(req_out), 32'h0);
    chk("midrst_ack_in",  32'(ack_in),  32'h0);
    chk("midrst_busy",    32'(busy),    32'h0);
    chk("midrst_evt_cnt", 32'(evt_cnt), 32'h0);
    rst_n = 1'b1;
    exp_q.push_back(2'd2);
    wait_idle("midrst");
    chk("midrst_done_cnt", 32'(evt_cnt), 32'd1);

    // Single request: req_out on the 3rd rising edge, then upstream ack.
    ack_delay = 10;
    exp_q.push_back(2'd2);
    req_in = 4'b0100;
    step();
    chk("lat_edge1", 32'(req_out), 32'h0);
    step();
    chk("lat_edge2", 32'(req_out), 32'h0);
    step();
    chk("lat_edge3", 32'(req_out), 32'h4);
    chk("lat_busy",  32'(busy),    32'h1);
    begin
      int unsigned n = 0;
      while (ack_in == 4'b0 && n < 100) begin step(); n++; end
      chk("single_ack_in", 32'(ack_in), 32'h4);
    end
    wait_idle("single");
    chk("single_cnt", 32'(evt_cnt), 32'd2);
    chk("sat_cnt_mid", 32'(evt_cnt_s), 32'd2);

    for (int i = 0; i < 5; i++) begin
      ack_delay = vecs[i].delay;
      for (int unsigned g = 0; g < vecs[i].ngrant; g++) begin
        logic [7:0] ord;
        ord = vecs[i].order >> (2 * g);
        exp_q.push_back(ord[1:0]);
      end
      req_in = vecs[i].req;
      wait_idle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_cnt", i), 32'(evt_cnt), 32'(vecs[i].cnt));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'h0);
    end

    // Withdrawn request: req_in[1] pulses once while index 0 is serviced.
    ack_delay = 12;
    exp_q.push_back(2'd0);
    req_in = 4'b0001;
    wait_grant("withdraw");
    run(2);
    req_in[1] = 1'b1;
    step();
    req_in[1] = 1'b0;
    wait_idle("withdraw");
    run(8);
    chk("withdraw_idle", 32'(busy), 32'h0);
    chk("withdraw_cnt",  32'(evt_cnt), 32'd14);

    // Spurious ack on a non-granted channel must not advance the FSM.
    spur_mask = 4'b0001;
    ack_out   = 4'b0001;
    ack_delay = 8;
    exp_q.push_back(2'd1);
    req_in = 4'b0010;
    wait_grant("spur");
    run(5);
    chk("spur_hold_req", 32'(req_out), 32'h2);
    chk("spur_hold_busy", 32'(busy), 32'h1);
    wait_idle("spur");
    spur_mask = '0;
    ack_out   = '0;
    run(3);
    chk("spur_cnt", 32'(evt_cnt), 32'd15);

    chk("sat_cnt", 32'(evt_cnt_s), 32'd3);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spike_arbiter.md
SPIKE_ARBITER -- requirements
Module: spike_arbiter

Interface
REQ-001 The block SHALL have parameter NEURON_IN, default 4, meaning the number of upstream requesters and the number of layer input channels.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning the width of the serviced-event counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port req_in, input, NEURON_IN bits: asynchronous 4-phase requests from the upstream neurons.
REQ-006 The block SHALL have port ack_in, output, NEURON_IN bits: acknowledges to the upstream neurons.
REQ-007 The block SHALL have port req_out, output, NEURON_IN bits: one-hot request to the downstream neuron layer.
REQ-008 The block SHALL have port ack_out, input, NEURON_IN bits: asynchronous acknowledges from the downstream layer.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-010 The block SHALL have port evt_cnt, output, CNT_W bits: count of completed transactions.

Function
REQ-011 req_in and ack_out SHALL each pass through a 2-flop synchronizer; all decisions SHALL use the synchronized values only.
REQ-012 The FSM SHALL have four states, IDLE, FWD, RLS and UPACK, with state transitions as defined in REQ-013 to REQ-017.
REQ-013 IDLE: if any synchronized req_in bit is high, select one by round-robin starting at index ptr, register it as idx, go to FWD; otherwise stay in IDLE.
REQ-014 FWD: req_out SHALL equal the one-hot of idx; on synchronized ack_out[idx]=1, go to RLS.
REQ-015 RLS: req_out SHALL be 0; on synchronized ack_out[idx]=0, go to UPACK.
REQ-016 UPACK: ack_in[idx] SHALL be 1; on synchronized req_in[idx]=0, deassert ack_in, set ptr=(idx+1) mod NEURON_IN, increment evt_cnt, and go to IDLE.
REQ-017 At most one req_out bit and at most one ack_in bit SHALL be high in any cycle, and never both at once.
REQ-018 All outputs SHALL be registered; req_out SHALL rise on the 3rd rising edge after a req_in rise while in IDLE (2 sync + 1 register).
REQ-019 Round-robin pointer wrap: after idx=NEURON_IN-1, ptr SHALL return to 0.
REQ-020 Requests arriving while not in IDLE SHALL be held by the requester and serviced in round-robin order; none SHALL be lost.
REQ-021 A request bit that drops before being granted SHALL NOT be granted.
REQ-022 A spurious ack_out bit other than idx SHALL be ignored.
REQ-023 evt_cnt SHALL saturate at all-ones and never wrap.
REQ-024 busy SHALL be 0 in IDLE and 1 in FWD, RLS and UPACK.

Reset
REQ-025 With rst_n=0 at a rising edge, the FSM SHALL go to IDLE and ptr, idx, evt_cnt, req_out, ack_in, busy and all synchronizer flops SHALL become 0.
REQ-026 Reset during FWD, RLS or UPACK SHALL abort the transaction without incrementing evt_cnt; requests still high after reset SHALL be re-arbitrated from index 0.

Structure
REQ-027 A shared package SHALL hold the state enum typedef (IDLE/FWD/RLS/UPACK) and the default NEURON_IN and CNT_W constants.
REQ-028 The round-robin selector SHALL be a sub-module rr_select (inputs: request vector, ptr; outputs: one-hot grant, index, valid), purely combinational.
REQ-029 The synchronizer SHALL be a generic vector 2-flop instance, used once for req_in and once for ack_out.

Verification
REQ-030 Single request: req_in=4'b0100 with the responder acking after 10 cycles -> req_out=4'b0100 at the 3rd edge, RLS, then ack_in=4'b0100; after req_in drops, evt_cnt=1.
REQ-031 Simultaneous request: req_in=4'b1111 held with ptr=0 -> grants in order 0,1,2,3, evt_cnt=4, and never two req_out bits high at once.
REQ-032 Fairness and wrap: after servicing index 3, req_in=4'b1001 -> index 0 is granted before index 3.
REQ-033 Mid-transaction reset: rst_n=0 for 1 cycle while in FWD with idx=2 -> all outputs 0 next cycle and evt_cnt unchanged; with req_in[2] still high, it is re-granted.
REQ-034 Saturation: CNT_W=2 with 5 transactions -> evt_cnt=3.
REQ-035 Withdrawn request: req_in[1] pulses high for 1 cycle while busy servicing index 0 -> index 1 is never granted.
